// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants for the data-memory port arbiter
package dmem_arb_pkg;

    // Default data-memory geometry: 256 words x 64 bits
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 64;

    // Read-return owner encoding
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

    // Arbiter states
    localparam logic [0:0] ARB_CPU_PRI    = 1'b0;
    localparam logic [0:0] ARB_HOST_FORCE = 1'b1;

endpackage

// File: rtl/dmem_rd_tag.sv
// rtl/dmem_rd_tag.sv - one-cycle read-return tracker for the data-memory port
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   issue_valid         a read is issued to memory this cycle
//   issue_owner         requester that issued the read (OWN_*)
//   cpu_rvalid          registered pulse: returning data belongs to the CPU
//   host_rvalid         registered pulse: returning data belongs to the host
module dmem_rd_tag
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [1:0] issue_owner,
    output logic       cpu_rvalid,
    output logic       host_rvalid
);

    logic       tag_valid;
    logic [1:0] tag_owner;

    // Reset discards any read in flight so no stale rvalid appears afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag_owner <= OWN_NONE;
        end else begin
            tag_valid <= issue_valid;
            tag_owner <= issue_valid ? issue_owner : OWN_NONE;
        end
    end

    assign cpu_rvalid  = tag_valid & (tag_owner == OWN_CPU);
    assign host_rvalid = tag_valid & (tag_owner == OWN_HOST);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CPU/host arbiter for the single-port data memory
//
// Optional feature macro: DMEM_ARB_LOCK_EN (host burst lock via host_lock).
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU MEM-stage access
//   cpu_stall                    CPU request not serviced this cycle
//   cpu_rvalid/rdata             CPU read return (one cycle after issue)
//   host_req/we/addr/wdata       host access, held until granted
//   host_gnt                     host request issued this cycle
//   host_rvalid/rdata            host read return (one cycle after issue)
//   host_lock                    hold port for host burst (lock build only)
//   mem_we/addr/wdata            memory command
//   mem_rdata                    memory read data, one cycle after address
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W        = DMEM_ADDR_W,
    parameter int DATA_W        = DMEM_DATA_W,
    parameter int HOST_MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_lock,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [0:0]        state, state_nxt;
    logic [3:0]        wait_cnt, wait_nxt;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic              lock_hold;
    logic              host_pri, host_granted, cpu_granted;
    logic              rd_issue;
    logic [1:0]        rd_owner;

`ifdef DMEM_ARB_LOCK_EN
    // Remembers whether the most recent grant went to the host
    logic last_host;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_host <= 1'b0;
        end else if (host_granted) begin
            last_host <= 1'b1;
        end else if (cpu_granted) begin
            last_host <= 1'b0;
        end
    end

    assign lock_hold = host_lock & last_host;
`else
    logic unused_host_lock;
    assign unused_host_lock = host_lock;
    assign lock_hold        = 1'b0;
`endif

    always_comb begin
        host_pri     = (state == ARB_HOST_FORCE) | lock_hold;
        host_granted = host_req & (host_pri | ~cpu_req);
        cpu_granted  = cpu_req & ~host_granted;

        // A withdrawn or served host request restarts the starvation count
        wait_nxt = wait_cnt;
        if (!host_req || host_granted) begin
            wait_nxt = 4'd0;
        end else if (wait_cnt != 4'hF) begin
            wait_nxt = wait_cnt + 4'd1;
        end

        // Entering HOST_FORCE on the cycle the count reaches the limit gives
        // the host the port on the very next cycle
        state_nxt = state;
        if (host_granted) begin
            state_nxt = ARB_CPU_PRI;
        end else if (state == ARB_CPU_PRI && host_req &&
                     wait_nxt >= 4'(HOST_MAX_WAIT)) begin
            state_nxt = ARB_HOST_FORCE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_CPU_PRI;
            wait_cnt   <= 4'd0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (host_granted || cpu_granted) begin
                addr_hold  <= mem_addr;
                wdata_hold <= mem_wdata;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_granted;
    assign host_gnt  = host_granted;

    // Memory command follows the winner; address/data hold when idle
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_hold;
        mem_wdata = wdata_hold;
        if (host_granted) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_granted) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign rd_issue = (host_granted & ~host_we) | (cpu_granted & ~cpu_we);
    assign rd_owner = host_granted ? OWN_HOST : (cpu_granted ? OWN_CPU : OWN_NONE);

    dmem_rd_tag u_rd_tag (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (rd_issue),
        .issue_owner (rd_owner),
        .cpu_rvalid  (cpu_rvalid),
        .host_rvalid (host_rvalid)
    );

    assign cpu_rdata  = mem_rdata;
    assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [7:0]  cpu_addr, host_addr;
    logic [63:0] cpu_wdata, host_wdata;
    logic        cpu_stall, cpu_rvalid, host_gnt, host_rvalid, mem_we;
    logic [63:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    logic [63:0] mem [256];

    typedef struct {
        logic [1:0]  own;
        logic [63:0] data;
    } exp_t;
    exp_t sbq[$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(8), .DATA_W(64), .HOST_MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_lock(host_lock),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory core
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid pops the oldest expected read return
    always @(negedge clk) begin
        if (!rst && (cpu_rvalid || host_rvalid)) begin
            if (sbq.size() == 0) begin
                chk("unexpected rvalid", {62'd0, host_rvalid, cpu_rvalid}, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rvalid owner", {62'd0, host_rvalid, cpu_rvalid}, {62'd0, e.own});
                chk("rdata", (e.own == OWN_HOST) ? host_rdata : cpu_rdata, e.data);
            end
        end
    end

    // One cycle: drive inputs, check grant/command mid-cycle, queue any read
    task automatic cyc(input string nm,
                       input logic cr, input logic cwe, input logic [7:0] ca, input logic [63:0] cd,
                       input logic hr, input logic hwe, input logic [7:0] ha, input logic [63:0] hd,
                       input logic hl,
                       input logic es, input logic eg, input logic ewe, input logic [7:0] ea,
                       input logic [1:0] rown, input logic [63:0] rdat);
        cpu_req = cr;  cpu_we = cwe;  cpu_addr = ca;  cpu_wdata = cd;
        host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hd;
        host_lock = hl;
        @(negedge clk);
        chk({nm, " cpu_stall"}, {63'd0, cpu_stall}, {63'd0, es});
        chk({nm, " host_gnt"}, {63'd0, host_gnt}, {63'd0, eg});
        chk({nm, " mem_we"}, {63'd0, mem_we}, {63'd0, ewe});
        chk({nm, " mem_addr"}, {56'd0, mem_addr}, {56'd0, ea});
        if (rown != OWN_NONE) sbq.push_back('{own: rown, data: rdat});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input string nm, input logic [7:0] ea);
        cyc(nm, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, ea, OWN_NONE, 64'h0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " cpu_stall"}, {63'd0, cpu_stall}, 64'd0);
        chk({nm, " cpu_rvalid"}, {63'd0, cpu_rvalid}, 64'd0);
        chk({nm, " host_gnt"}, {63'd0, host_gnt}, 64'd0);
        chk({nm, " host_rvalid"}, {63'd0, host_rvalid}, 64'd0);
        chk({nm, " mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({nm, " mem_addr"}, {56'd0, mem_addr}, 64'd0);
        chk({nm, " mem_wdata"}, mem_wdata, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Preload through host writes
        cyc("ld5", 0, 0, 8'h00, 64'h0, 1, 1, 8'h05, 64'hDEAD_BEEF, 0, 0, 1, 1, 8'h05, OWN_NONE, 64'h0);
        cyc("ld1", 0, 0, 8'h00, 64'h0, 1, 1, 8'h01, 64'h1111, 0, 0, 1, 1, 8'h01, OWN_NONE, 64'h0);
        cyc("ld2", 0, 0, 8'h00, 64'h0, 1, 1, 8'h02, 64'h2222, 0, 0, 1, 1, 8'h02, OWN_NONE, 64'h0);

        // Lone CPU read
        cyc("cpu_rd5", 1, 0, 8'h05, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 8'h05, OWN_CPU, 64'hDEAD_BEEF);
        idle_cyc("idle_hold", 8'h05);

        // Starvation: CPU wins 3 cycles, host forced on the 4th
        for (int i = 0; i < 3; i++)
            cyc("starve", 1, 1, 8'h20 + 8'(i), 64'(i), 1, 0, 8'h02, 64'h0, 0, 0, 0, 1, 8'h20 + 8'(i), OWN_NONE, 64'h0);
        cyc("force", 1, 1, 8'h23, 64'h3, 1, 0, 8'h02, 64'h0, 0, 1, 1, 0, 8'h02, OWN_HOST, 64'h2222);
        // New host request after forced grant loses again; then it is withdrawn
        for (int i = 0; i < 2; i++)
            cyc("post_force", 1, 1, 8'h24 + 8'(i), 64'h0, 1, 0, 8'h01, 64'h0, 0, 0, 0, 1, 8'h24 + 8'(i), OWN_NONE, 64'h0);
        cyc("withdraw", 1, 1, 8'h26, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 1, 8'h26, OWN_NONE, 64'h0);
        for (int i = 0; i < 3; i++)
            cyc("restarve", 1, 1, 8'h27 + 8'(i), 64'h0, 1, 1, 8'h30, 64'h5, 0, 0, 0, 1, 8'h27 + 8'(i), OWN_NONE, 64'h0);
        cyc("reforce", 1, 1, 8'h2A, 64'h0, 1, 1, 8'h30, 64'h5, 0, 1, 1, 1, 8'h30, OWN_NONE, 64'h0);

        // Host write then CPU read of the same word
        cyc("host_wr10", 0, 0, 8'h00, 64'h0, 1, 1, 8'h10, 64'h1234, 0, 0, 1, 1, 8'h10, OWN_NONE, 64'h0);
        cyc("cpu_rd10", 1, 0, 8'h10, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 8'h10, OWN_CPU, 64'h1234);

        // Alternating owners, back-to-back reads
        for (int i = 0; i < 2; i++) begin
            cyc("alt_cpu", 1, 0, 8'h01, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 8'h01, OWN_CPU, 64'h1111);
            cyc("alt_host", 0, 0, 8'h00, 64'h0, 1, 0, 8'h02, 64'h0, 0, 0, 1, 0, 8'h02, OWN_HOST, 64'h2222);
        end
        idle_cyc("alt_idle", 8'h02);

        // Reset with a read in flight and HOST_FORCE pending
        for (int i = 0; i < 2; i++)
            cyc("pre_rst", 1, 0, 8'h05, 64'h0, 1, 0, 8'h02, 64'h0, 0, 0, 0, 0, 8'h05, OWN_CPU, 64'hDEAD_BEEF);
        cyc("rst_rd", 1, 0, 8'h05, 64'h0, 1, 0, 8'h02, 64'h0, 0, 0, 0, 0, 8'h05, OWN_NONE, 64'h0);
        rst = 1'b1;
        cpu_req = 0; host_req = 0; cpu_addr = 0; host_addr = 0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        chk("mid_reset cpu_rvalid", {63'd0, cpu_rvalid}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("post_rst", 1, 1, 8'h40 + 8'(i), 64'h0, 1, 1, 8'h41, 64'h9, 0, 0, 0, 1, 8'h40 + 8'(i), OWN_NONE, 64'h0);
        cyc("post_rst_force", 1, 1, 8'h43, 64'h0, 1, 1, 8'h41, 64'h9, 0, 1, 1, 1, 8'h41, OWN_NONE, 64'h0);

`ifdef DMEM_ARB_LOCK_EN
        // Host burst under lock holds off the CPU until the lock drops
        cyc("lock_own", 0, 0, 8'h00, 64'h0, 1, 1, 8'h50, 64'h7, 0, 0, 1, 1, 8'h50, OWN_NONE, 64'h0);
        for (int i = 0; i < 4; i++)
            cyc("locked", 1, 1, 8'h60, 64'h0, 1, 1, 8'h51 + 8'(i), 64'h8, 1, 1, 1, 1, 8'h51 + 8'(i), OWN_NONE, 64'h0);
        cyc("unlocked", 1, 1, 8'h60, 64'h0, 1, 1, 8'h55, 64'h8, 0, 0, 0, 1, 8'h60, OWN_NONE, 64'h0);
`endif

        cpu_req = 0; host_req = 0; host_lock = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
